// File: rtl/jellyvl_cdc_handshake_src.sv
// Source-side endpoint of a 4-phase req/ack CDC handshake: holds one word on cdc_data
// while cdc_req is high and waits for the synchronized ack. Optional watchdog: JELLYVL_CDC_HANDSHAKE_TIMEOUT_EN.
module jellyvl_cdc_handshake_src #(
  parameter int DATA_BITS      = 32,
  parameter int ACK_SYNC_FF    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 rst_n,
  input  logic                 clk,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_BITS-1:0] cdc_data,
  output logic                 cdc_req,
  input  logic                 cdc_ack,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ACK_H = 2'd1,
    ST_WAIT_ACK_L = 2'd2
  } state_t;

  logic [ACK_SYNC_FF-1:0] r_ack_sync;
  logic                   w_ack_s;
  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_req;
  logic                   w_req_next;
  logic                   w_accept;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_busy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_SYNC_FF-2:0], cdc_ack};
    end
  end

  assign w_ack_s = r_ack_sync[ACK_SYNC_FF-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid && !w_ack_s) begin
          w_accept     = 1'b1;
          w_req_next   = 1'b1;
          w_state_next = ST_WAIT_ACK_H;
        end
      end
      ST_WAIT_ACK_H: begin
        // A dropping ack here is a glitch; only a high level moves us on.
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_state_next = ST_WAIT_ACK_L;
        end
      end
      ST_WAIT_ACK_L: begin
        if (!w_ack_s) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_busy  <= (w_state_next != ST_IDLE);
      if (w_accept) begin
        r_data <= s_data;
      end
    end
  end

  assign s_ready  = (r_state == ST_IDLE) && !w_ack_s;
  assign cdc_req  = r_req;
  assign cdc_data = r_data;
  assign busy     = r_busy;

`ifdef JELLYVL_CDC_HANDSHAKE_TIMEOUT_EN
  localparam int                CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(TIMEOUT_CYCLES);

  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_next;
  logic                r_timeout;

  // Counts cycles spent in the current wait state; saturates at the limit.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if ((r_state != ST_IDLE) && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_cnt_next == CNT_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jellyvl_cdc_handshake_src.sv
// Bench for jellyvl_cdc_handshake_src: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_jellyvl_cdc_handshake_src;

  localparam int DW = 32;
  localparam int NS = 2;
  localparam int TO = 16;
`ifdef JELLYVL_CDC_HANDSHAKE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] cdc_data;
  logic          cdc_req;
  logic          cdc_ack;
  logic          busy;
  logic          timeout;

  logic          man_ack  = 1'b0;
  logic          resp_en  = 1'b0;
  logic          resp_ack = 1'b0;
  assign cdc_ack = resp_en ? resp_ack : man_ack;

  jellyvl_cdc_handshake_src #(
    .DATA_BITS      (DW),
    .ACK_SYNC_FF    (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .rst_n    (rst_n),
    .clk      (clk),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .cdc_data (cdc_data),
    .cdc_req  (cdc_req),
    .cdc_ack  (cdc_ack),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = idle, 1 = request raised, 2 = waiting for ack to drop.
  // The synchronized ack is the cdc_ack sample taken NS clock edges earlier.
  int            m_phase;
  int            m_nxt;
  int            m_cyc;
  bit            m_to;
  logic [DW-1:0] m_data;
  bit            m_hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cyc   = 0;
      m_to    = 1'b0;
      m_data  = '0;
      m_hist.delete();
      for (int i = 0; i < NS; i++) m_hist.push_back(1'b0);
    end else begin
      m_nxt = m_phase;
      if (m_phase == 0 && s_valid && !m_hist[0]) begin
        m_nxt  = 1;
        m_data = s_data;
      end else if (m_phase == 1 && m_hist[0]) begin
        m_nxt = 2;
      end else if (m_phase == 2 && !m_hist[0]) begin
        m_nxt = 0;
      end
      if (m_nxt != m_phase) m_cyc = 0;
      else if (m_phase != 0) m_cyc++;
      if (m_nxt != 0 && m_cyc >= TO) m_to = 1'b1;
      m_phase = m_nxt;
      m_hist.push_back(cdc_ack);
      void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    check("model_s_ready", s_ready, (m_phase == 0 && !m_hist[0]));
    check("model_cdc_req", cdc_req, (m_phase == 1));
    check("model_busy", busy, (m_phase != 0));
    check("model_cdc_data", cdc_data, m_data);
    check("model_timeout", timeout, (m_to && TO_EN));
  end

  // Responder: mirrors cdc_req onto cdc_ack three samples later, captures data on ack rise.
  logic [2:0]    r_h = '0;
  logic [DW-1:0] cap_q[$];

  always @(posedge clk) begin
    #1;
    if (!resp_en) begin
      r_h      = '0;
      resp_ack = 1'b0;
    end else begin
      r_h = {r_h[1:0], cdc_req};
      if (r_h[2] && !resp_ack) cap_q.push_back(cdc_data);
      resp_ack = r_h[2];
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return cdc_req;
      1:       return cdc_ack;
      2:       return s_ready;
      default: return busy;
    endcase
  endfunction

  function automatic logic [DW-1:0] cap_at(input int idx);
    if (idx < cap_q.size()) return cap_q[idx];
    return 'x;
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
    int n = 0;
    while (sig(sel) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== val) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait expired after %0d cycles", name, budget);
    end
  endtask

  task automatic count_edges(input int sel, input logic val, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (sig(sel) !== val && n < 50);
  endtask

  int  acc;
  int  n_edges;
  bit  hs;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_cdc_req", cdc_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cdc_data", cdc_data, 32'h0);
    check("rst_timeout", timeout, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst_n   = 1'b1;
    resp_en = 1'b1;

    // Single transfer: s_valid pulse in cycle 10, req/data visible in cycle 11
    repeat (7) @(posedge clk);
    #1 s_data = 32'hDEADBEEF;
    s_valid = 1'b1;
    @(negedge clk);
    check("single_req_before", cdc_req, 1'b0);
    check("single_ready_before", s_ready, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    s_data  = '0;
    @(negedge clk);
    check("single_req", cdc_req, 1'b1);
    check("single_data", cdc_data, 32'hDEADBEEF);
    check("single_busy", busy, 1'b1);
    check("single_ready_low", s_ready, 1'b0);
    wait_sig(1, 1'b1, 20, "single_ack_rise");
    count_edges(0, 1'b0, n_edges);
    check("single_req_fall_edges", n_edges, 32'd3);
    wait_sig(1, 1'b0, 20, "single_ack_fall");
    count_edges(2, 1'b1, n_edges);
    check("single_ready_rise_edges", n_edges, 32'd3);
    check("single_cap_count", cap_q.size(), 32'd1);
    check("single_cap_data", cap_at(0), 32'hDEADBEEF);

    // Stream 1..8 with s_valid held high
    cap_q.delete();
    acc = 0;
    @(posedge clk);
    #1 s_data = 32'd1;
    s_valid = 1'b1;
    for (int c = 0; c < 400 && acc < 8; c++) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        s_data = DW'(acc + 1);
        if (acc == 8) s_valid = 1'b0;
      end
    end
    @(negedge clk);
    wait_sig(3, 1'b0, 200, "stream_idle");
    repeat (6) @(negedge clk);
    check("stream_accepts", acc, 32'd8);
    check("stream_cap_count", cap_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("stream_cap_data", cap_at(i), 32'(i + 1));

    // Data stability while busy
    @(posedge clk);
    #1 s_data = 32'h12345678;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      check("stable_data", cdc_data, 32'h12345678);
      @(posedge clk);
      #1 s_data = $urandom;
    end
    check("stable_data_idle", cdc_data, 32'h12345678);
    repeat (6) @(negedge clk);

    // Reset mid-transfer, then a fresh transfer of 0x55
    @(posedge clk);
    #1 resp_en = 1'b0;
    man_ack = 1'b0;
    s_data  = 32'hA5A5A5A5;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("midrst_req_before", cdc_req, 1'b1);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_req", cdc_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data", cdc_data, 32'h0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    cap_q.delete();
    resp_en = 1'b1;
    s_data  = 32'h55;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("post_rst_req", cdc_req, 1'b1);
    wait_sig(3, 1'b0, 100, "post_rst_idle");
    repeat (6) @(negedge clk);
    check("post_rst_cap_count", cap_q.size(), 32'd1);
    check("post_rst_cap_data", cap_at(0), 32'h55);
    check("post_rst_ready", s_ready, 1'b1);

    // Watchdog: ack never rises
    @(posedge clk);
    #1 resp_en = 1'b0;
    s_data  = 32'h0F0F0F0F;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("to_req", cdc_req, 1'b1);
    repeat (15) @(negedge clk);
    check("to_cycle15", timeout, 1'b0);
    @(negedge clk);
    check("to_cycle16", timeout, TO_EN);
    repeat (10) @(negedge clk);
    check("to_sticky", timeout, TO_EN);
    check("to_still_waiting", cdc_req, 1'b1);

    // Stale ack at reset release
    @(posedge clk);
    #1 rst_n = 1'b0;
    man_ack = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("stale_ready", s_ready, 1'b0);
    check("stale_req", cdc_req, 1'b0);
    check("stale_timeout", timeout, 1'b0);
    @(posedge clk);
    #1 s_data = 32'h77;
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("stale_no_req", cdc_req, 1'b0);
    check("stale_no_busy", busy, 1'b0);
    @(posedge clk);
    #1 man_ack = 1'b0;
    count_edges(2, 1'b1, n_edges);
    check("stale_ready_edges", n_edges, 32'd2);
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check("stale_accept_req", cdc_req, 1'b1);
    check("stale_accept_data", cdc_data, 32'h77);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
